// File: rtl/serial_alu_sequencer.sv
// rtl/serial_alu_sequencer.sv - bit-serial MIPS ALU controller with start/done handshake
module serial_alu_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_ctrl,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             carry_out
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t r_state;
   state_t w_next_state;

   // Operands and decode latched at accept; later input changes are invisible
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_ainv;
   logic             r_binv;
   logic [1:0]       r_op;
   logic             r_arith;
   logic             r_slt;

   // Serial datapath state
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic [WIDTH-1:0] r_shadow;
   logic             r_sum_msb;
   logic             r_ovf_cap;
   logic             r_cout_cap;

   // Decode of the incoming control code
   logic             w_dec_ainv;
   logic             w_dec_binv;
   logic             w_dec_cin;
   logic [1:0]       w_dec_op;
   logic             w_dec_arith;
   logic             w_dec_slt;

   // 1-bit ALU slice signals
   logic             w_ai;
   logic             w_bi;
   logic             w_sum;
   logic             w_slice_cout;
   logic             w_slice_bit;
   logic             w_last;
   logic [WIDTH-1:0] w_fix_value;

   // Map the ALU-control code onto Ainvert/Binvert/CarryIn/Operation.
   // Invalid codes select the "less" operation with less=0 and no arithmetic
   // flags, so they naturally produce an all-zero result.
   always_comb begin
      w_dec_ainv  = 1'b0;
      w_dec_binv  = 1'b0;
      w_dec_cin   = 1'b0;
      w_dec_op    = 2'b11;
      w_dec_arith = 1'b0;
      w_dec_slt   = 1'b0;
      case (alu_ctrl)
         4'b0000: begin
            w_dec_op = 2'b00;
         end
         4'b0001: begin
            w_dec_op = 2'b01;
         end
         4'b0010: begin
            w_dec_op    = 2'b10;
            w_dec_arith = 1'b1;
         end
         4'b0110: begin
            w_dec_binv  = 1'b1;
            w_dec_cin   = 1'b1;
            w_dec_op    = 2'b10;
            w_dec_arith = 1'b1;
         end
         4'b0111: begin
            w_dec_binv  = 1'b1;
            w_dec_cin   = 1'b1;
            w_dec_op    = 2'b11;
            w_dec_arith = 1'b1;
            w_dec_slt   = 1'b1;
         end
         4'b1100: begin
            w_dec_ainv = 1'b1;
            w_dec_binv = 1'b1;
            w_dec_op   = 2'b00;
         end
         default: begin
            w_dec_op = 2'b11;
         end
      endcase
   end

   // One ALU slice evaluated at the current bit index; the adder always runs
   // so the MSB sum/carry are available for the SLT fix-up and flags.
   always_comb begin
      w_ai         = r_a[r_cnt] ^ r_ainv;
      w_bi         = r_b[r_cnt] ^ r_binv;
      w_sum        = w_ai ^ w_bi ^ r_carry;
      w_slice_cout = (w_ai & w_bi) | (w_ai & r_carry) | (w_bi & r_carry);
      case (r_op)
         2'b00:   w_slice_bit = w_ai & w_bi;
         2'b01:   w_slice_bit = w_ai | w_bi;
         2'b10:   w_slice_bit = w_sum;
         default: w_slice_bit = 1'b0;
      endcase
   end

   assign w_last = (r_cnt == LAST_BIT);

   // Value committed to the result register in FIX (signed-correct less for SLT)
   assign w_fix_value = r_slt ? {{(WIDTH-1){1'b0}}, r_sum_msb ^ r_ovf_cap} : r_shadow;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; start outside IDLE is simply dropped
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next_state = S_RUN;
         S_RUN:   if (w_last) w_next_state = S_FIX;
         S_FIX:   w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   assign busy = (r_state != S_IDLE);
   assign done = (r_state == S_DONE);

   // Operand capture, serial bit processing and result/flag commit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a        <= '0;
         r_b        <= '0;
         r_ainv     <= 1'b0;
         r_binv     <= 1'b0;
         r_op       <= 2'b00;
         r_arith    <= 1'b0;
         r_slt      <= 1'b0;
         r_cnt      <= '0;
         r_carry    <= 1'b0;
         r_shadow   <= '0;
         r_sum_msb  <= 1'b0;
         r_ovf_cap  <= 1'b0;
         r_cout_cap <= 1'b0;
         result     <= '0;
         zero       <= 1'b0;
         overflow   <= 1'b0;
         carry_out  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_ainv   <= w_dec_ainv;
                  r_binv   <= w_dec_binv;
                  r_op     <= w_dec_op;
                  r_arith  <= w_dec_arith;
                  r_slt    <= w_dec_slt;
                  r_cnt    <= '0;
                  r_carry  <= w_dec_cin;
                  r_shadow <= '0;
               end
            end
            S_RUN: begin
               r_shadow[r_cnt] <= w_slice_bit;
               r_carry         <= w_slice_cout;
               r_cnt           <= r_cnt + CW'(1);
               if (w_last) begin
                  r_sum_msb  <= w_sum;
                  r_ovf_cap  <= r_carry ^ w_slice_cout;
                  r_cout_cap <= w_slice_cout;
               end
            end
            S_FIX: begin
               result    <= w_fix_value;
               zero      <= (w_fix_value == '0);
               overflow  <= r_arith & r_ovf_cap;
               carry_out <= r_arith & r_cout_cap;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// tb/tb_serial_alu_sequencer.sv - scoreboard bench for serial_alu_sequencer
module tb_serial_alu_sequencer;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [3:0]   alu_ctrl;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         zero;
   logic         overflow;
   logic         carry_out;

   typedef struct {
      logic [W-1:0] res;
      logic         z;
      logic         ovf;
      logic         cout;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   serial_alu_sequencer #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .alu_ctrl  (alu_ctrl),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .zero      (zero),
      .overflow  (overflow),
      .carry_out (carry_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] c);
      exp_t       e;
      logic [W:0] s;
      e.res = '0; e.ovf = 1'b0; e.cout = 1'b0;
      case (c)
         4'b0000: e.res = x & y;
         4'b0001: e.res = x | y;
         4'b1100: e.res = ~(x | y);
         4'b0010: begin
            s      = {1'b0, x} + {1'b0, y};
            e.res  = s[W-1:0];
            e.cout = s[W];
            e.ovf  = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
         end
         4'b0110, 4'b0111: begin
            s      = {1'b0, x} + {1'b0, ~y} + 1;
            e.cout = s[W];
            e.ovf  = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
            if (c == 4'b0110) e.res = s[W-1:0];
            else              e.res = ($signed(x) < $signed(y)) ? 1 : 0;
         end
         default: e.res = '0;
      endcase
      e.z = (e.res == '0);
      return e;
   endfunction

   // Issue one operation, optionally hammering start/operands while busy
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] c, input bit junk);
      int   n;
      int   lat;
      exp_t e;
      n = 0;
      while (busy !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("idle_before_start", busy, 0);
      sb.push_back(model(x, y, c));
      a = x; b = y; alu_ctrl = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_accept", busy, 1);
      lat = 1;
      while (done !== 1'b1 && lat < 100) begin
         if (junk) begin
            start    = 1'($urandom_range(0, 1));
            a        = $urandom;
            b        = $urandom;
            alu_ctrl = 4'($urandom);
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      chk("done_latency", lat, W + 2);
      e = sb.pop_front();
      chk("result", result, e.res);
      chk("zero", zero, e.z);
      chk("overflow", overflow, e.ovf);
      chk("carry_out", carry_out, e.cout);
      @(negedge clk);
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
      chk("result_held", result, e.res);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; alu_ctrl = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_zero", zero, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_cout", carry_out, 0);
      rst = 1'b0;
      @(negedge clk);

      run_op(32'd5,          32'd7,          4'b0010, 0);
      run_op(32'd3,          32'd5,          4'b0110, 0);
      run_op(32'd9,          32'd9,          4'b0110, 0);
      run_op(32'h7FFFFFFF,   32'd1,          4'b0010, 0);
      run_op(32'h7FFFFFFF,   32'h80000000,   4'b0111, 0);
      run_op(32'hFFFFFFFF,   32'd1,          4'b0111, 0);
      run_op(32'd0,          32'd0,          4'b1100, 0);
      run_op(32'hF0,         32'h0F,         4'b0000, 0);
      run_op(32'hF0,         32'h0F,         4'b0001, 0);
      run_op(32'hFF,         32'd1,          4'b0011, 0);
      run_op(32'h80000000,   32'h80000000,   4'b0010, 0);
      run_op(32'h80000000,   32'd1,          4'b0111, 1);
      run_op(32'h12345678,   32'h0F0F0F0F,   4'b0001, 1);

      // Asynchronous reset in the middle of RUN
      a = 32'hFFFF; b = 32'd1; alu_ctrl = 4'b0010; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      chk("busy_before_rst", busy, 1);
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_result", result, 0);
      chk("midrst_zero", zero, 0);
      chk("midrst_ovf", overflow, 0);
      chk("midrst_cout", carry_out, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_op(32'd2, 32'd3, 4'b0010, 0);

      for (int i = 0; i < 6; i++) begin
         logic [3:0] c;
         case (i % 6)
            0: c = 4'b0000;
            1: c = 4'b0001;
            2: c = 4'b0010;
            3: c = 4'b0110;
            4: c = 4'b0111;
            default: c = 4'b1100;
         endcase
         run_op($urandom, $urandom, c, 0);
      end

      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
